// File: rtl/sched_pkg.sv
// Shared definitions for the round-robin task scheduler family:
// FSM state encoding, default sizing and a constant-width helper.
package sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SWITCH = 2'd2
    } state_t;

    localparam int DEFAULT_N       = 4;
    localparam int DEFAULT_QUANTUM = 8;

    // Ceiling log2, usable in parameter defaults.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit after index last,
// searching upward with wrap-around.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic           any,
    output logic [IDW-1:0] winner
);

    logic [IDW-1:0] idx;

    // NOTE: every variable written here gets a default first, otherwise
    // paths that skip an assignment infer latches.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = '0;
        // Scan from the farthest offset down so the nearest requester wins.
        for (int off = N; off >= 1; off--) begin
            idx = IDW'((int'(last) + off) % N);
            if (req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/rr_task_scheduler.sv
// Time-sliced round-robin scheduler: one owner at a time, preemption on
// quantum expiry, and a one-cycle grant-free gap between owners.
module rr_task_scheduler
    import sched_pkg::*;
#(
    parameter int N       = DEFAULT_N,
    parameter int QUANTUM = DEFAULT_QUANTUM,
    parameter int IDW     = clog2(N),
    parameter int CW      = clog2(QUANTUM)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   done,
    output logic [N-1:0]   grant,
    output logic           busy,
    output logic [IDW-1:0] cur_id,
    output logic [CW-1:0]  slice_cnt,
    output logic           preempt
);

    state_t         state, state_n;
    logic [IDW-1:0] last, last_n;
    logic [N-1:0]   grant_n;
    logic           busy_n;
    logic [IDW-1:0] cur_id_n;
    logic [CW-1:0]  slice_n;
    logic           preempt_n;

    logic           pick_any;
    logic [IDW-1:0] pick_winner;
    logic           owner_release;
    logic           slice_expired;
    logic           others_waiting;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req    (req),
        .last   (last),
        .any    (pick_any),
        .winner (pick_winner)
    );

    assign owner_release  = done[cur_id] | ~req[cur_id];
    assign slice_expired  = (slice_cnt == CW'(QUANTUM - 1));
    assign others_waiting = |(req & ~grant);

    always_comb begin
        state_n   = state;
        last_n    = last;
        grant_n   = grant;
        busy_n    = busy;
        cur_id_n  = cur_id;
        slice_n   = slice_cnt;
        preempt_n = 1'b0;
        case (state)
            IDLE, SWITCH: begin
                slice_n = '0;
                if (pick_any) begin
                    state_n              = RUN;
                    grant_n              = '0;
                    grant_n[pick_winner] = 1'b1;
                    busy_n               = 1'b1;
                    cur_id_n             = pick_winner;
                end else begin
                    state_n = IDLE;
                    grant_n = '0;
                    busy_n  = 1'b0;
                end
            end
            RUN: begin
                // A voluntary release outranks expiry, so no preempt pulse then.
                if (owner_release || (slice_expired && others_waiting)) begin
                    state_n   = SWITCH;
                    grant_n   = '0;
                    busy_n    = 1'b0;
                    slice_n   = '0;
                    last_n    = cur_id;
                    preempt_n = ~owner_release;
                end else if (slice_expired) begin
                    slice_n = '0;
                end else begin
                    slice_n = slice_cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                busy_n  = 1'b0;
                slice_n = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= IDW'(N - 1);
            grant     <= '0;
            busy      <= 1'b0;
            cur_id    <= '0;
            slice_cnt <= '0;
            preempt   <= 1'b0;
        end else begin
            state     <= state_n;
            last      <= last_n;
            grant     <= grant_n;
            busy      <= busy_n;
            cur_id    <= cur_id_n;
            slice_cnt <= slice_n;
            preempt   <= preempt_n;
        end
    end

endmodule

// File: tb/tb_rr_task_scheduler.sv
// Table-driven, scoreboarded bench for rr_task_scheduler with N=4, QUANTUM=4.
module tb_rr_task_scheduler;

    localparam int N       = 4;
    localparam int QUANTUM = 4;
    localparam int IDW     = 2;
    localparam int CW      = 2;

    typedef struct packed {
        logic [3:0] grant;
        logic       busy;
        logic [1:0] cur_id;
        logic [1:0] slice_cnt;
        logic       preempt;
    } out_t;

    typedef struct {
        logic [3:0] req;
        logic [3:0] done;
        out_t       exp;
    } vec_t;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   done;
    logic [N-1:0]   grant;
    logic           busy;
    logic [IDW-1:0] cur_id;
    logic [CW-1:0]  slice_cnt;
    logic           preempt;

    int   checks;
    int   errors;
    vec_t vecs[$];
    out_t exp_q[$];

    rr_task_scheduler #(
        .N       (N),
        .QUANTUM (QUANTUM),
        .IDW     (IDW),
        .CW      (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .grant     (grant),
        .busy      (busy),
        .cur_id    (cur_id),
        .slice_cnt (slice_cnt),
        .preempt   (preempt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic out_t mk(input logic [3:0] g, input logic [1:0] id,
                                input logic [1:0] sc, input logic pre);
        out_t o;
        o.grant     = g;
        o.busy      = |g;
        o.cur_id    = id;
        o.slice_cnt = sc;
        o.preempt   = pre;
        return o;
    endfunction

    task automatic add(input logic [3:0] r, input logic [3:0] d, input logic [3:0] g,
                       input logic [1:0] id, input logic [1:0] sc, input logic pre);
        vec_t v;
        v.req  = r;
        v.done = d;
        v.exp  = mk(g, id, sc, pre);
        vecs.push_back(v);
    endtask

    function automatic out_t sample();
        out_t o;
        o.grant     = grant;
        o.busy      = busy;
        o.cur_id    = cur_id;
        o.slice_cnt = slice_cnt;
        o.preempt   = preempt;
        return o;
    endfunction

    task automatic check(input string name, input out_t actual, input out_t expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got grant=%b busy=%b cur_id=%0d slice=%0d preempt=%b, want grant=%b busy=%b cur_id=%0d slice=%0d preempt=%b",
                     name, actual.grant, actual.busy, actual.cur_id, actual.slice_cnt, actual.preempt,
                     expected.grant, expected.busy, expected.cur_id, expected.slice_cnt, expected.preempt);
        end
    endtask

    // Drive inputs just after an edge, queue the expectation, compare after the next edge.
    task automatic apply(input string name, input logic [3:0] r, input logic [3:0] d, input out_t e);
        out_t exp_v;
        req  = r;
        done = d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            exp_v = exp_q.pop_front();
            check(name, sample(), exp_v);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Idle, reset, start-up and test 1 tail.
        add(4'b1111, 4'b0000, 4'b0001, 2'd0, 2'd0, 1'b0);
        add(4'b0000, 4'b0000, 4'b0000, 2'd0, 2'd0, 1'b0);
        add(4'b0000, 4'b0000, 4'b0000, 2'd0, 2'd0, 1'b0);
        // Lone requester renews its slice forever without preemption.
        for (int i = 0; i < 12; i++) begin
            add(4'b0100, 4'b0000, 4'b0100, 2'd2, 2'(i % 4), 1'b0);
        end
        add(4'b0000, 4'b0000, 4'b0000, 2'd2, 2'd0, 1'b0);
        add(4'b0000, 4'b0000, 4'b0000, 2'd2, 2'd0, 1'b0);
        // Two contenders alternate through quantum expiry.
        add(4'b0011, 4'b0000, 4'b0001, 2'd0, 2'd0, 1'b0);
        add(4'b0011, 4'b0000, 4'b0001, 2'd0, 2'd1, 1'b0);
        add(4'b0011, 4'b0000, 4'b0001, 2'd0, 2'd2, 1'b0);
        add(4'b0011, 4'b0000, 4'b0001, 2'd0, 2'd3, 1'b0);
        add(4'b0011, 4'b0000, 4'b0000, 2'd0, 2'd0, 1'b1);
        add(4'b0011, 4'b0000, 4'b0010, 2'd1, 2'd0, 1'b0);
        add(4'b0011, 4'b0000, 4'b0010, 2'd1, 2'd1, 1'b0);
        add(4'b0011, 4'b0000, 4'b0010, 2'd1, 2'd2, 1'b0);
        add(4'b0011, 4'b0000, 4'b0010, 2'd1, 2'd3, 1'b0);
        add(4'b0011, 4'b0000, 4'b0000, 2'd1, 2'd0, 1'b1);
        add(4'b0011, 4'b0000, 4'b0001, 2'd0, 2'd0, 1'b0);
        // Early done with wrap-around to task 3.
        add(4'b1001, 4'b0000, 4'b0001, 2'd0, 2'd1, 1'b0);
        add(4'b1001, 4'b0001, 4'b0000, 2'd0, 2'd0, 1'b0);
        add(4'b1001, 4'b0000, 4'b1000, 2'd3, 2'd0, 1'b0);
        // Owner drops req; then done coinciding with expiry is a plain release.
        add(4'b0011, 4'b0000, 4'b0000, 2'd3, 2'd0, 1'b0);
        add(4'b0011, 4'b0000, 4'b0001, 2'd0, 2'd0, 1'b0);
        add(4'b0011, 4'b0000, 4'b0001, 2'd0, 2'd1, 1'b0);
        add(4'b0011, 4'b0000, 4'b0001, 2'd0, 2'd2, 1'b0);
        add(4'b0011, 4'b0000, 4'b0001, 2'd0, 2'd3, 1'b0);
        add(4'b0011, 4'b0001, 4'b0000, 2'd0, 2'd0, 1'b0);
        add(4'b0011, 4'b0000, 4'b0010, 2'd1, 2'd0, 1'b0);
        // Foreign done bits are ignored.
        add(4'b0011, 4'b0101, 4'b0010, 2'd1, 2'd1, 1'b0);
        add(4'b0011, 4'b0000, 4'b0010, 2'd1, 2'd2, 1'b0);

        rst  = 1'b1;
        req  = 4'b1111;
        done = 4'b0000;
        #1;
        for (int i = 0; i < 5; i++) begin
            apply($sformatf("reset_hold_%0d", i), 4'b1111, 4'b0000, mk(4'b0000, 2'd0, 2'd0, 1'b0));
        end
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply($sformatf("vec_%0d", i), vecs[i].req, vecs[i].done, vecs[i].exp);
        end

        // Asynchronous reset in the middle of a RUN slice.
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_clear", sample(), mk(4'b0000, 2'd0, 2'd0, 1'b0));
        #1;
        @(posedge clk);
        #1;
        apply("reset_held", 4'b0110, 4'b0000, mk(4'b0000, 2'd0, 2'd0, 1'b0));
        rst = 1'b0;
        apply("post_reset_pointer", 4'b0110, 4'b0000, mk(4'b0010, 2'd1, 2'd0, 1'b0));
        apply("post_reset_slice", 4'b0110, 4'b0000, mk(4'b0010, 2'd1, 2'd1, 1'b0));

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
